// File: rtl/coderom_loader.sv
// coderom_loader: streams the boot image into the code ROM banks, then sequences CPU reads.
// Define CHECKSUM_EN to require a 16-bit sum trailer after the image (adds CHECK and ERR).
module coderom_loader #(
    parameter int BANKS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        reload,
    input  logic        cpu_req,
    input  logic [14:0] cpu_a,
    output logic        cpu_ack,
    output logic [7:0]  cpu_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        err,
    output logic [12:0] rom_a,
    output logic [3:0]  rom_ce_n,
    input  logic [7:0]  rom_out,
    output logic        wr_en,
    output logic [1:0]  wr_bank,
    output logic [7:0]  wr_d,
    output logic [1:0]  dbg_state
);

    localparam logic [14:0] LAST_IDX = 15'(BANKS * 8192 - 1);
    localparam logic [2:0]  NBANKS   = 3'(BANKS);

    typedef enum logic [1:0] {ST_LOAD, ST_CHECK, ST_RUN, ST_ERR} state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_CE, RD_ACK} rd_phase_t;

    state_t      r_state;
    rd_phase_t   r_rd_phase;
    logic [14:0] r_cnt;
    logic        r_rd_ok;
    logic        r_reload_pend;
    logic        r_ld_ready;
    logic        r_cpu_ack;
    logic [7:0]  r_cpu_data;
    logic        r_cpu_hold;
    logic        r_done;
    logic [12:0] r_rom_a;
    logic [3:0]  r_rom_ce_n;
    logic        r_wr_en;
    logic [1:0]  r_wr_bank;
    logic [7:0]  r_wr_d;

    // Byte handshake: a byte transfers on any clock edge where ld_valid and ld_ready are both high;
    // ld_ready is registered and does not depend on ld_valid.
    logic w_accept;
    logic w_bank_ok;
    logic w_take_reload;

    assign w_accept      = ld_valid & r_ld_ready;
    assign w_bank_ok     = {1'b0, cpu_a[14:13]} < NBANKS;
    assign w_take_reload = ((r_rd_phase == RD_IDLE) && reload) ||
                           ((r_rd_phase == RD_ACK) && (reload || r_reload_pend));

`ifdef CHECKSUM_EN
    logic [15:0] r_sum;
    logic [7:0]  r_chk_hi;
    logic        r_chk_phase;
    logic        r_err;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_LOAD;
            r_rd_phase    <= RD_IDLE;
            r_cnt         <= '0;
            r_rd_ok       <= 1'b0;
            r_reload_pend <= 1'b0;
            r_ld_ready    <= 1'b0;
            r_cpu_ack     <= 1'b0;
            r_cpu_data    <= '0;
            r_cpu_hold    <= 1'b1;
            r_done        <= 1'b0;
            r_rom_a       <= '0;
            r_rom_ce_n    <= 4'hF;
            r_wr_en       <= 1'b0;
            r_wr_bank     <= '0;
            r_wr_d        <= '0;
`ifdef CHECKSUM_EN
            r_sum         <= '0;
            r_chk_hi      <= '0;
            r_chk_phase   <= 1'b0;
            r_err         <= 1'b0;
`endif
        end else begin
            r_wr_en   <= 1'b0;
            r_cpu_ack <= 1'b0;
            case (r_state)
                ST_LOAD: begin
                    r_ld_ready <= 1'b1;
                    if (w_accept) begin
                        r_wr_en   <= 1'b1;
                        r_wr_bank <= r_cnt[14:13];
                        r_rom_a   <= r_cnt[12:0];
                        r_wr_d    <= ld_data;
                        r_cnt     <= r_cnt + 15'd1;
`ifdef CHECKSUM_EN
                        r_sum     <= r_sum + {8'h00, ld_data};
                        if (r_cnt == LAST_IDX) r_state <= ST_CHECK;
`else
                        if (r_cnt == LAST_IDX) begin
                            r_state    <= ST_RUN;
                            r_ld_ready <= 1'b0;
                            r_cpu_hold <= 1'b0;
                            r_done     <= 1'b1;
                        end
`endif
                    end
                end
`ifdef CHECKSUM_EN
                ST_CHECK: begin
                    if (w_accept) begin
                        if (!r_chk_phase) begin
                            r_chk_hi    <= ld_data;
                            r_chk_phase <= 1'b1;
                        end else begin
                            r_chk_phase <= 1'b0;
                            r_ld_ready  <= 1'b0;
                            if ({r_chk_hi, ld_data} == r_sum) begin
                                r_state    <= ST_RUN;
                                r_cpu_hold <= 1'b0;
                                r_done     <= 1'b1;
                            end else begin
                                r_state <= ST_ERR;
                                r_err   <= 1'b1;
                            end
                        end
                    end
                end
                ST_ERR: begin
                    r_ld_ready <= 1'b0;
                    r_rom_ce_n <= 4'hF;
                end
`endif
                ST_RUN: begin
                    if (w_take_reload) begin
                        r_state       <= ST_LOAD;
                        r_rd_phase    <= RD_IDLE;
                        r_cnt         <= '0;
                        r_done        <= 1'b0;
                        r_cpu_hold    <= 1'b1;
                        r_ld_ready    <= 1'b1;
                        r_reload_pend <= 1'b0;
`ifdef CHECKSUM_EN
                        r_sum         <= '0;
                        r_chk_phase   <= 1'b0;
`endif
                    end else begin
                        case (r_rd_phase)
                            RD_IDLE: begin
                                if (cpu_req) begin
                                    r_rd_phase <= RD_CE;
                                    r_rom_a    <= cpu_a[12:0];
                                    r_rd_ok    <= w_bank_ok;
                                    if (w_bank_ok) r_rom_ce_n <= ~(4'b0001 << cpu_a[14:13]);
                                end
                            end
                            RD_CE: begin
                                r_cpu_data <= r_rd_ok ? rom_out : 8'h00;
                                r_cpu_ack  <= 1'b1;
                                r_rom_ce_n <= 4'hF;
                                r_rd_phase <= RD_ACK;
                                if (reload) r_reload_pend <= 1'b1;
                            end
                            default: r_rd_phase <= RD_IDLE;
                        endcase
                    end
                end
                default: r_state <= r_state;
            endcase
        end
    end

    assign ld_ready  = r_ld_ready;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_data  = r_cpu_data;
    assign cpu_hold  = r_cpu_hold;
    assign done      = r_done;
    assign rom_a     = r_rom_a;
    assign rom_ce_n  = r_rom_ce_n;
    assign wr_en     = r_wr_en;
    assign wr_bank   = r_wr_bank;
    assign wr_d      = r_wr_d;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_coderom_loader.sv
// tb_coderom_loader: self-checking bench for coderom_loader with a behavioural ROM array model.
// Three banks keep two full image loads within the cycle budget while leaving bank 3 out of range.
module tb_coderom_loader;
    localparam int BANKS   = 3;
    localparam int IMG_LEN = BANKS * 8192;

    logic        clk = 1'b0;
    logic        reset, ld_valid, reload, cpu_req;
    logic [7:0]  ld_data;
    logic [14:0] cpu_a;
    logic        ld_ready, cpu_ack, cpu_hold, done, err, wr_en;
    logic [7:0]  cpu_data, rom_out, wr_d;
    logic [12:0] rom_a;
    logic [3:0]  rom_ce_n;
    logic [1:0]  wr_bank, dbg_state;

    always #5 clk = ~clk;

    coderom_loader #(.BANKS(BANKS)) dut (
        .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .reload(reload), .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_ack(cpu_ack), .cpu_data(cpu_data),
        .cpu_hold(cpu_hold), .done(done), .err(err), .rom_a(rom_a), .rom_ce_n(rom_ce_n),
        .rom_out(rom_out), .wr_en(wr_en), .wr_bank(wr_bank), .wr_d(wr_d), .dbg_state(dbg_state)
    );

    typedef struct {
        logic [14:0] a;
        logic [3:0]  ce_n;
        logic [12:0] ra;
        logic [7:0]  d;
    } rd_vec_t;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rom_mem [4][8192];
    logic [22:0] exp_q[$];
    logic [7:0]  rd_q[$];
    int          wr_count = 0;
    int          wr_errs = 0;
    int          bus_errs = 0;
    int          load_base = 0;
    bit          in_load = 1'b0;
    logic [22:0] wr_first, wr_8192;

    always_comb begin
        rom_out = 8'h00;
        for (int b = 0; b < 4; b++)
            if (!rom_ce_n[b]) rom_out = rom_mem[b][rom_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] img_byte(input int pat, input int idx);
        logic [31:0] v;
        v = idx;
        if (pat == 0) return v[7:0];
        return v[7:0] ^ v[15:8] ^ 8'h5A;
    endfunction

    // ROM array model and write scoreboard, sampled mid-cycle on the falling edge.
    initial begin
        for (int b = 0; b < 4; b++)
            for (int i = 0; i < 8192; i++) rom_mem[b][i] = 8'hA5;
        forever begin
            logic [22:0] w, e;
            @(negedge clk);
            if (wr_en) begin
                w = {wr_bank, rom_a, wr_d};
                if (wr_count - load_base == 0) wr_first = w;
                if (wr_count - load_base == 8192) wr_8192 = w;
                wr_count++;
                if (exp_q.size() == 0) wr_errs++;
                else begin
                    e = exp_q.pop_front();
                    if (e !== w) wr_errs++;
                end
                rom_mem[wr_bank][rom_a] = wr_d;
            end
            if (in_load && (rom_ce_n !== 4'hF || cpu_ack)) bus_errs++;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ld_ready"}, ld_ready, 0);
        check({tag, "_cpu_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cpu_ack"}, cpu_ack, 0);
        check({tag, "_cpu_data"}, cpu_data, 0);
        check({tag, "_rom_ce_n"}, rom_ce_n, 4'hF);
        check({tag, "_rom_a"}, rom_a, 0);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_bank"}, wr_bank, 0);
        check({tag, "_wr_d"}, wr_d, 0);
    endtask

    // Called #1 after a clock edge; returns #1 after an edge, one cycle past the final accept.
    task automatic load_image(input string tag, input int pat, input bit throttle, input bit good);
        int idx, cyc, errs0;
        logic [15:0] sum;
        logic hold_before;
        idx = 0; cyc = 0; sum = 0; hold_before = 1'b0;
        errs0 = wr_errs;
        load_base = wr_count;
        in_load = 1'b1;
        while (idx < IMG_LEN && cyc < 4 * IMG_LEN) begin
            if (throttle && cyc[0]) begin
                ld_valid = 1'b0;
                ld_data = 8'($urandom_range(0, 255));
            end else begin
                ld_valid = 1'b1;
                ld_data = img_byte(pat, idx);
            end
            if (ld_valid && ld_ready) begin
                exp_q.push_back({2'(idx >> 13), 13'(idx), ld_data});
                sum = sum + {8'h00, ld_data};
                idx++;
                hold_before = cpu_hold;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ld_valid = 1'b0;
        check({tag, "_bytes_accepted"}, idx, IMG_LEN);
        check({tag, "_hold_at_last"}, hold_before, 1);
`ifdef CHECKSUM_EN
        check({tag, "_ready_into_check"}, ld_ready, 1);
        check({tag, "_hold_in_check"}, cpu_hold, 1);
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1;
            ld_data = (k == 0) ? sum[15:8] : (good ? sum[7:0] : sum[7:0] + 8'd1);
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        check({tag, "_chk_done"}, done, good ? 1 : 0);
        check({tag, "_chk_err"}, err, good ? 0 : 1);
        check({tag, "_chk_hold"}, cpu_hold, good ? 0 : 1);
        check({tag, "_chk_ready"}, ld_ready, 0);
`else
        check({tag, "_hold_after_last"}, cpu_hold, 0);
        check({tag, "_ready_after_last"}, ld_ready, 0);
        check({tag, "_done_after_last"}, done, 1);
        check({tag, "_err"}, err, good ? 0 : 0);
`endif
        in_load = 1'b0;
        @(posedge clk); #1;
        check({tag, "_wr_count"}, wr_count - load_base, IMG_LEN);
        check({tag, "_wr_stream_errs"}, wr_errs - errs0, 0);
        check({tag, "_wr_q_empty"}, exp_q.size(), 0);
        check({tag, "_first_wr_addr"}, wr_first[22:8], 0);
    endtask

    task automatic do_read(input string tag, input rd_vec_t v);
        int lat;
        bit got;
        cpu_req = 1'b1;
        cpu_a = v.a;
        rd_q.push_back(v.d);
        @(posedge clk); #1;
        check({tag, "_ce_n"}, rom_ce_n, v.ce_n);
        check({tag, "_rom_a"}, rom_a, v.ra);
        check({tag, "_early_ack"}, cpu_ack, 0);
        lat = 1; got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ack) begin
                got = 1'b1;
                check({tag, "_data"}, cpu_data, rd_q.pop_front());
                check({tag, "_ce_released"}, rom_ce_n, 4'hF);
            end
        end
        check({tag, "_latency"}, lat, 2);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check({tag, "_ack_pulse"}, cpu_ack, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        rd_vec_t tbl1[8];
        rd_vec_t tbl2[3];
        int lat;
        bit got;

        tbl1[0] = '{15'h4005, 4'b1011, 13'h0005, 8'h05};
        tbl1[1] = '{15'h0000, 4'b1110, 13'h0000, 8'h00};
        tbl1[2] = '{15'h1FFF, 4'b1110, 13'h1FFF, 8'hFF};
        tbl1[3] = '{15'h2000, 4'b1101, 13'h0000, 8'h00};
        tbl1[4] = '{15'h3A7C, 4'b1101, 13'h1A7C, 8'h7C};
        tbl1[5] = '{15'h5FFF, 4'b1011, 13'h1FFF, 8'hFF};
        tbl1[6] = '{15'h6000, 4'b1111, 13'h0000, 8'h00};
        tbl1[7] = '{15'h7ABC, 4'b1111, 13'h1ABC, 8'h00};
        tbl2[0] = '{15'h0123, 4'b1110, 13'h0123, img_byte(1, 'h0123)};
        tbl2[1] = '{15'h3456, 4'b1101, 13'h1456, img_byte(1, 'h3456)};
        tbl2[2] = '{15'h5ABC, 4'b1011, 13'h1ABC, img_byte(1, 'h5ABC)};

        // Clock/reset block
        reset = 1'b1; ld_valid = 1'b0; ld_data = '0; reload = 1'b0; cpu_req = 1'b0; cpu_a = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        reset = 1'b0;
        @(posedge clk); #1;
        check("ready_first_cycle", ld_ready, 1);
        check("hold_first_cycle", cpu_hold, 1);

        // Abort a load after 100 bytes
        in_load = 1'b1;
        load_base = wr_count;
        for (int i = 0; i < 100; i++) begin
            ld_valid = 1'b1;
            ld_data = 8'(i) ^ 8'hC3;
            exp_q.push_back({2'b00, 13'(i), ld_data});
            @(posedge clk); #1;
        end
        ld_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midload");
        check("partial_wr_count", wr_count - load_base, 100);
        check("partial_wr_errs", wr_errs, 0);
        check("partial_q_empty", exp_q.size(), 0);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;

        // Full load, ld_valid held high, then table of reads
        load_image("load1", 0, 1'b0, 1'b1);
        check("load1_byte8192", wr_8192, {2'd1, 13'd0, 8'h00});
        check("load_bus_quiet", bus_errs, 0);
        for (int i = 0; i < 8; i++) do_read($sformatf("rd1_%0d", i), tbl1[i]);

        // Reload pulsed in the middle of a read
        cpu_req = 1'b1; cpu_a = 15'h0123;
        rd_q.push_back(img_byte(0, 'h0123));
        @(posedge clk); #1;
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        check("reload_rd_ack", cpu_ack, 1);
        check("reload_rd_data", cpu_data, rd_q.pop_front());
        cpu_req = 1'b0;
        @(posedge clk); #1;
        check("reload_ld_ready", ld_ready, 1);
        check("reload_done_clr", done, 0);
        check("reload_hold", cpu_hold, 1);

        // Throttled reload of a new image with a CPU request pending throughout
        cpu_req = 1'b1; cpu_a = 15'h2345;
`ifdef CHECKSUM_EN
        load_image("load2", 1, 1'b1, 1'b0);
        check("load2_bus_quiet", bus_errs, 0);
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (cpu_ack) got = 1'b1;
        end
        check("err_no_ack", got, 0);
        check("err_sticky", err, 1);
        check("err_hold", cpu_hold, 1);
        check("err_ready", ld_ready, 0);
        check("err_ce", rom_ce_n, 4'hF);
        check("err_ignores_reload", done, 0);
        cpu_req = 1'b0;
`else
        load_image("load2", 1, 1'b1, 1'b1);
        check("load2_bus_quiet", bus_errs, 0);
        lat = 0; got = 1'b0;
        while (!got && lat < 8) begin
            @(posedge clk); #1;
            lat++;
            if (cpu_ack) begin
                got = 1'b1;
                check("pending_rd_data", cpu_data, img_byte(1, 'h2345));
            end
        end
        check("pending_rd_served", got, 1);
        cpu_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) do_read($sformatf("rd2_%0d", i), tbl2[i]);
`endif

        check("final_wr_q_empty", exp_q.size(), 0);
        check("final_rd_q_empty", rd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/coderom_loader.md
# coderom_loader

Boot-time loader and runtime access sequencer for the four 8 KB code ROM banks. After reset it holds the CPU off and streams the program image from a byte-wide source into the banks, bank 0 first. It then serves CPU read requests by decoding the bank, driving the active-low bank chip enables and shared address, and returning registered data with an acknowledge. It sits between the boot image source, the CPU bus interface and the code ROM arrays.

## Interface
- BANKS, 4, number of 8 KB banks loaded and decoded (1..4); image length = BANKS*8192 bytes
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  image byte available
- ld_data  in  8  image byte
- ld_ready  out  1  loader accepts a byte this cycle
- reload  in  1  single-cycle request to re-run the load from RUN
- cpu_req  in  1  CPU read request; held until cpu_ack
- cpu_a  in  15  CPU byte address; [14:13] bank, [12:0] offset
- cpu_ack  out  1  one-cycle pulse, cpu_data valid
- cpu_data  out  8  registered read data
- cpu_hold  out  1  CPU held off (high during load/check/error)
- done  out  1  image loaded (and verified, if enabled)
- err  out  1  checksum mismatch
- rom_a  out  13  shared ROM address
- rom_ce_n  out  4  active-low bank enables; at most one low
- rom_out  in  8  ROM read data (combinational from rom_a / rom_ce_n)
- wr_en  out  1  ROM write strobe
- wr_bank  out  2  bank written
- wr_d  out  8  write data

## Operation
- States: LOAD, CHECK (only with CHECKSUM_EN), RUN, ERR. Reset enters LOAD.
- LOAD:
  - ld_ready = 1.
  - A byte is accepted when ld_valid & ld_ready.
  - 15-bit counter cnt is 0 at LOAD entry. On accept: wr_bank = cnt[14:13], rom_a = cnt[12:0], wr_d = ld_data; cnt increments.
  - After byte BANKS*8192-1 is accepted: go to CHECK, or to RUN if checksum is disabled.
  - cpu_req is ignored: no ack, no ce.
- CHECK:
  - ld_ready = 1.
  - Accepts two bytes: expected sum high byte, then low byte.
  - Compares against the running 16-bit sum of all image bytes (mod 2^16).
  - Match: go to RUN. Mismatch: go to ERR.
- RUN:
  - cpu_hold = 0, done = 1, ld_ready = 0.
  - Read sequence: the idle controller samples cpu_req = 1 at cycle N.
    - N+1: rom_ce_n[cpu_a[14:13]] = 0, rom_a = cpu_a[12:0].
    - N+2: cpu_data is registered from rom_out, cpu_ack = 1, all rom_ce_n = 1.
  - Next request sampled no earlier than N+3.
  - Bank >= BANKS: no ce asserted; ack at N+2 with cpu_data = 8'h00.
- reload:
  - Sampled in RUN with no read in flight: next cycle goes to LOAD. cnt, sum, done clear; cpu_hold = 1.
  - Sampled during a read: latched, taken the cycle after cpu_ack.
  - Ignored outside RUN.
- ERR:
  - err = 1, cpu_hold = 1, ld_ready = 0, all ce high. Ignores reload.
  - Exits only on reset.

## Timing
- Outputs under reset and in the first cycle after reset:
  - reset asserted: ld_ready = 0, cpu_hold = 1, done = 0, err = 0, cpu_ack = 0, cpu_data = 0, rom_ce_n = 4'hF, rom_a = 0, wr_en = 0, wr_bank = 0, wr_d = 0.
  - ld_ready rises in the first cycle after reset deasserts.
- All outputs are registered.
- Write latency: byte accepted at cycle N produces a wr_en pulse at N+1 with its address, bank and data.
- Load throughput: one byte per cycle with ld_valid held high. 32768-byte image loads in 32768 cycles (+2 with checksum).
- Last-byte boundary:
  - Last image byte accepted at N: ld_ready stays 1 into CHECK; in RUN (no checksum) ld_ready = 0 from N+1.
  - cpu_hold = 0 from N+1 (no checksum), or from the cycle after the low checksum byte is accepted.
- Read latency: 2 cycles request-to-ack, one read outstanding.
- reset mid-load or mid-read:
  - Aborts immediately.
  - A partial image is discarded logically; the ROM contents are not cleared.
  - No ack is issued for the aborted read.
- reload and cpu_req in the same idle cycle: reload wins; the request stays pending and is served after the next load completes.

## Configuration
- CHECKSUM_EN defined:
  - CHECK and ERR states present.
  - Two trailer bytes are required after the image.
  - err reports a mismatch.
- CHECKSUM_EN undefined:
  - LOAD goes directly to RUN after the last image byte.
  - No trailer bytes are consumed.
  - err is tied 0 and the sum logic is removed.

## Test plan
- Full load, BANKS=4, ld_valid held high, bytes = cnt[7:0]:
  - wr_en pulses 32768 times.
  - Byte 8192 writes wr_bank=1, rom_a=0, wr_d=8'h00.
  - cpu_hold falls exactly 1 cycle after the last accept (no checksum).
- Throttled load with ld_valid toggling every other cycle:
  - Exactly 32768 writes in order, no skipped or duplicated addresses.
- Read in RUN:
  - cpu_req with cpu_a=15'h4005: rom_ce_n=4'b1011 and rom_a=13'h0005 at N+1.
  - cpu_ack at N+2 with cpu_data equal to the loaded byte.
- CHECKSUM_EN:
  - Correct trailer: done=1, err=0.
  - Trailer with low byte off by 1: err=1, cpu_hold stays 1, ld_ready=0, reload ignored.
- Reload during a read:
  - reload pulsed at N+1 of a read: ack still at N+2.
  - LOAD entered at N+3 with ld_ready=1, done=0.
- Reset asserted mid-load after 100 bytes:
  - All outputs return to their reset values.
  - The next load restarts at wr_bank=0, rom_a=0.
